uart_rx_param: RTL and testbench

Parametrised UART receiver, successor to the fixed 8-bit receiver in the serial path. It:
- generates its own oversampling tick from the system clock;
- synchronises and mid-bit-samples the line;
- supports configurable data width, parity mode and stop-bit count;
- presents each received word on a valid/ready handshake, with parity, framing and overrun status.

It sits between the pad-side rx line and the consumer logic (register file or FIFO). The external frequency divider and the separate shift-register wiring are no longer needed.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_param_if.sv | 29 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx_param.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive/transmit family: parity modes,
// FSM state encoding and the default baud/clock setup.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int DEFAULT_CLK_HZ        = 50_000_000;
    localparam int DEFAULT_BAUD          = 115_200;
    localparam int DEFAULT_OVERSAMPLE    = 16;
    // 50 MHz / (115200 * 16) rounds down to 27
    localparam int DEFAULT_CLKS_PER_TICK = DEFAULT_CLK_HZ / (DEFAULT_BAUD * DEFAULT_OVERSAMPLE);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5,
        BREAK  = 3'd6
    } uart_state_t;

endpackage

// File: rtl/uart_rx_param_if.sv
// Word handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready,
        output parity_err,
        output frame_err,
        output overrun
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready,
        input  parity_err,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clk pulse every CLKS_PER_TICK cycles,
// realignable by restart so the next tick lands a full period later.
module uart_baud_tick #(
    parameter int CLKS_PER_TICK = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised, mid-bit sampled line, optional
// parity, 1-2 stop bits, valid/ready word output with error and overrun status.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int PARITY_MODE   = PAR_NONE,
    parameter int STOP_BITS     = 1,
    parameter int OVERSAMPLE    = DEFAULT_OVERSAMPLE,
    parameter int CLKS_PER_TICK = DEFAULT_CLKS_PER_TICK
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic busy,
    uart_rx_param_if.master rx_if
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    logic rx_meta_reg, rxs_reg, rxs_prev_reg;
    logic tick, restart, start_edge, bit_point;

    uart_state_t          state_reg, state_next;
    logic [SW-1:0]        sample_cnt_reg, sample_cnt_next;
    logic [3:0]           bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 par_cap_reg, par_cap_next;
    logic                 frm_cap_reg, frm_cap_next;
    logic                 par_x;

    logic [DATA_BITS-1:0] data_out_reg;
    logic                 data_valid_reg, parity_err_reg, frame_err_reg, overrun_reg;

    uart_baud_tick #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // Synchroniser resets to the idle-high line level so reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_reg  <= 1'b1;
            rxs_reg      <= 1'b1;
            rxs_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg  <= rx;
            rxs_reg      <= rx_meta_reg;
            rxs_prev_reg <= rxs_reg;
        end
    end

    assign start_edge = rxs_prev_reg && !rxs_reg;
    assign bit_point  = tick && (sample_cnt_reg == FULL_LAST);
    assign par_x      = (^shift_reg) ^ rxs_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            sample_cnt_reg <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            par_cap_reg    <= 1'b0;
            frm_cap_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sample_cnt_reg <= sample_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            par_cap_reg    <= par_cap_next;
            frm_cap_reg    <= frm_cap_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        sample_cnt_next = sample_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        par_cap_next    = par_cap_reg;
        frm_cap_next    = frm_cap_reg;
        restart         = 1'b0;

        // Sample counter advances on every tick inside a frame; sample points reset it below
        if (tick && (state_reg inside {START, DATA, PARITY, STOP})) begin
            sample_cnt_next = sample_cnt_reg + SW'(1);
        end

        case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    state_next      = START;
                    sample_cnt_next = '0;
                    bit_cnt_next    = '0;
                    par_cap_next    = 1'b0;
                    frm_cap_next    = 1'b0;
                    restart         = 1'b1;
                end
            end
            START: begin
                if (tick && (sample_cnt_reg == HALF_LAST)) begin
                    sample_cnt_next = '0;
                    if (rxs_reg) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (bit_point) begin
                    sample_cnt_next = '0;
                    shift_next      = {rxs_reg, shift_reg[DATA_BITS-1:1]};
                    if (bit_cnt_reg == DATA_LAST) begin
                        bit_cnt_next = '0;
                        if (PARITY_MODE != PAR_NONE) begin
                            state_next = PARITY;
                        end else begin
                            state_next = STOP;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_point) begin
                    sample_cnt_next = '0;
                    par_cap_next    = (PARITY_MODE == PAR_ODD) ? !par_x : par_x;
                    state_next      = STOP;
                end
            end
            STOP: begin
                if (bit_point) begin
                    sample_cnt_next = '0;
                    if (!rxs_reg) begin
                        frm_cap_next = 1'b1;
                    end
                    if (bit_cnt_reg == STOP_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = DONE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
            DONE: begin
                if (rxs_reg) begin
                    state_next = IDLE;
                end else begin
                    state_next = BREAK;
                end
            end
            BREAK: begin
                if (rxs_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A freshly completed word always wins over a same-cycle acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else if (state_reg == DONE) begin
            data_out_reg   <= shift_reg;
            data_valid_reg <= 1'b1;
            parity_err_reg <= par_cap_reg;
            frame_err_reg  <= frm_cap_reg;
            if (data_valid_reg && !rx_if.data_ready) begin
                overrun_reg <= 1'b1;
            end
        end else if (data_valid_reg && rx_if.data_ready) begin
            data_valid_reg <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end
    end

    assign rx_if.data_out   = data_out_reg;
    assign rx_if.data_valid = data_valid_reg;
    assign rx_if.parity_err = (PARITY_MODE != PAR_NONE) && parity_err_reg;
    assign rx_if.frame_err  = frame_err_reg;
    assign rx_if.overrun    = overrun_reg;
    assign busy             = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: five receiver configurations on one clock,
// one bit = 16 clk (CLKS_PER_TICK = 1, OVERSAMPLE = 16).
module tb_uart_rx_param;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rxl;
    logic [4:0] busy;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         start_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param_if #(.DATA_BITS(8)) if0 ();
    uart_rx_param_if #(.DATA_BITS(8)) if1 ();
    uart_rx_param_if #(.DATA_BITS(8)) if2 ();
    uart_rx_param_if #(.DATA_BITS(8)) if3 ();
    uart_rx_param_if #(.DATA_BITS(9)) if4 ();

    uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(PAR_NONE), .STOP_BITS(1), .OVERSAMPLE(16), .CLKS_PER_TICK(1))
        u0 (.clk(clk), .reset(reset), .rx(rxl[0]), .busy(busy[0]), .rx_if(if0));
    uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(PAR_EVEN), .STOP_BITS(1), .OVERSAMPLE(16), .CLKS_PER_TICK(1))
        u1 (.clk(clk), .reset(reset), .rx(rxl[1]), .busy(busy[1]), .rx_if(if1));
    uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(PAR_ODD), .STOP_BITS(1), .OVERSAMPLE(16), .CLKS_PER_TICK(1))
        u2 (.clk(clk), .reset(reset), .rx(rxl[2]), .busy(busy[2]), .rx_if(if2));
    uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(PAR_NONE), .STOP_BITS(2), .OVERSAMPLE(16), .CLKS_PER_TICK(1))
        u3 (.clk(clk), .reset(reset), .rx(rxl[3]), .busy(busy[3]), .rx_if(if3));
    uart_rx_param #(.DATA_BITS(9), .PARITY_MODE(PAR_NONE), .STOP_BITS(1), .OVERSAMPLE(16), .CLKS_PER_TICK(1))
        u4 (.clk(clk), .reset(reset), .rx(rxl[4]), .busy(busy[4]), .rx_if(if4));

    // Word monitor: counts valid cycles and captures the word/flags while valid is high
    logic [4:0] vld, pe, fe, vld_q;
    logic [8:0] dat [5];
    logic [8:0] cap_d [5];
    logic [4:0] cap_pe, cap_fe;
    int         vcyc [5];
    int         rise [5];

    assign vld = {if4.data_valid, if3.data_valid, if2.data_valid, if1.data_valid, if0.data_valid};
    assign pe  = {if4.parity_err, if3.parity_err, if2.parity_err, if1.parity_err, if0.parity_err};
    assign fe  = {if4.frame_err, if3.frame_err, if2.frame_err, if1.frame_err, if0.frame_err};
    assign dat[0] = {1'b0, if0.data_out};
    assign dat[1] = {1'b0, if1.data_out};
    assign dat[2] = {1'b0, if2.data_out};
    assign dat[3] = {1'b0, if3.data_out};
    assign dat[4] = if4.data_out;

    initial begin
        vld_q = '0;
        cap_pe = '0;
        cap_fe = '0;
        for (int i = 0; i < 5; i++) begin
            vcyc[i]  = 0;
            rise[i]  = 0;
            cap_d[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 5; i++) begin
                if (vld[i]) begin
                    vcyc[i]++;
                    cap_d[i]  = dat[i];
                    cap_pe[i] = pe[i];
                    cap_fe[i] = fe[i];
                    if (!vld_q[i]) rise[i] = cyc;
                end
            end
            vld_q = vld;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives the first ndrive bits of a frame (start, data LSB first, parity, stops)
    task automatic send_frame(input int idx, input logic [8:0] d, input int nd, input int np,
                              input logic pb, input int ns, input logic [1:0] sv, input int ndrive);
        logic [15:0] bits;
        int          n;
        bits = '1;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nd; i++) begin bits[n] = d[i]; n++; end
        if (np != 0) begin bits[n] = pb; n++; end
        for (int i = 0; i < ns; i++) begin bits[n] = sv[i]; n++; end
        $display("send rx%0d data=0x%0h nbits=%0d par=%0d/%0b stop=%0d/%b driven=%0d",
                 idx, d, nd, np, pb, ns, sv, (ndrive < n) ? ndrive : n);
        start_cyc = cyc;
        for (int i = 0; i < n && i < ndrive; i++) begin
            rxl[idx] = bits[i];
            step(16);
        end
    endtask

    int         base, lat, drop;
    logic       seen;
    logic [3:0] exp_pe;

    initial begin
        rxl   = '1;
        reset = 1'b1;
        if0.data_ready = 1'b1;
        if1.data_ready = 1'b1;
        if2.data_ready = 1'b1;
        if3.data_ready = 1'b1;
        if4.data_ready = 1'b1;
        step(3);

        // Reset state
        chk("rst_valid", 32'(if0.data_valid), 0);
        chk("rst_data", 32'(if4.data_out), 0);
        chk("rst_flags", {29'd0, if0.parity_err, if0.frame_err, if0.overrun}, 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        step(20);

        // 1: basic receive of 0xA5
        base = vcyc[0];
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11, 99);
        step(20);
        lat = rise[0] - start_cyc;
        $display("t1 latency %0d clk", lat);
        chk("t1_valid_cycles", 32'(vcyc[0] - base), 1);
        chk("t1_data", 32'(cap_d[0]), 32'h0A5);
        chk("t1_pe_fe", {30'd0, cap_pe[0], cap_fe[0]}, 0);
        chk("t1_latency_ok", 32'(lat >= 154 && lat <= 163), 1);
        chk("t1_overrun", 32'(if0.overrun), 0);

        // 2: parity on 0x03; even then odd, parity bit 0 then 1
        exp_pe = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx  = 1 + k / 2;
            base = vcyc[idx];
            send_frame(idx, 9'h003, 8, 1, 1'(k % 2), 1, 2'b11, 99);
            step(20);
            chk("t2_valid_cycles", 32'(vcyc[idx] - base), 1);
            chk("t2_data", 32'(cap_d[idx]), 32'h003);
            chk("t2_parity_err", 32'(cap_pe[idx]), 32'(exp_pe[k]));
            chk("t2_frame_err", 32'(cap_fe[idx]), 0);
        end

        // 3: framing error, second stop bit low, line held low (break)
        base = vcyc[3];
        send_frame(3, 9'h055, 8, 0, 1'b0, 2, 2'b01, 99);
        chk("t3_valid_cycles", 32'(vcyc[3] - base), 1);
        chk("t3_data", 32'(cap_d[3]), 32'h055);
        chk("t3_frame_err", 32'(cap_fe[3]), 1);
        step(24);
        chk("t3_busy_in_break", 32'(busy[3]), 1);
        rxl[3] = 1'b1;
        step(2);
        chk("t3_busy_after_2", 32'(busy[3]), 1);
        step(1);
        chk("t3_busy_after_3", 32'(busy[3]), 0);
        step(40);
        chk("t3_no_spurious", 32'(vcyc[3] - base), 1);

        // 4: 4-clk glitch rejected
        base = vcyc[0];
        seen = 1'b0;
        drop = 0;
        rxl[0] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (k == 4) rxl[0] = 1'b1;
            if (busy[0]) seen = 1'b1;
            else if (seen && drop == 0) drop = k;
        end
        chk("t4_busy_seen", 32'(seen), 1);
        chk("t4_drop_in_12", 32'(drop > 0 && drop <= 12), 1);
        chk("t4_no_word", 32'(vcyc[0] - base), 0);

        // 5: handshake with consumer stalled, then overrun
        if0.data_ready = 1'b0;
        send_frame(0, 9'h011, 8, 0, 1'b0, 1, 2'b11, 99);
        step(4);
        chk("t5_valid_held", 32'(if0.data_valid), 1);
        chk("t5_data_11", 32'(if0.data_out), 32'h11);
        chk("t5_no_overrun", 32'(if0.overrun), 0);
        send_frame(0, 9'h022, 8, 0, 1'b0, 1, 2'b11, 99);
        step(4);
        chk("t5_overrun", 32'(if0.overrun), 1);
        chk("t5_data_22", 32'(if0.data_out), 32'h22);
        chk("t5_valid_still", 32'(if0.data_valid), 1);
        if0.data_ready = 1'b1;
        step(1);
        if0.data_ready = 1'b0;
        chk("t5_valid_cleared", 32'(if0.data_valid), 0);
        step(30);
        chk("t5_overrun_sticky", 32'(if0.overrun), 1);
        if0.data_ready = 1'b1;

        // 6: 9-bit words and reset mid-frame
        base = vcyc[4];
        send_frame(4, 9'h1FF, 9, 0, 1'b0, 1, 2'b11, 99);
        step(20);
        chk("t6_data_1ff", 32'(cap_d[4]), 32'h1FF);
        chk("t6_valid_cycles", 32'(vcyc[4] - base), 1);
        send_frame(4, 9'h0AA, 9, 0, 1'b0, 1, 2'b11, 4);
        rxl[4] = 1'b1;
        step(8);
        chk("t6_busy_mid_frame", 32'(busy[4]), 1);
        reset = 1'b1;
        step(1);
        chk("t6_rst_data", 32'(if4.data_out), 0);
        chk("t6_rst_flags", {28'd0, if4.data_valid, if4.parity_err, if4.frame_err, if4.overrun}, 0);
        chk("t6_rst_busy", 32'(busy[4]), 0);
        chk("t6_rst_overrun_u0", 32'(if0.overrun), 0);
        reset = 1'b0;
        step(20);
        base = vcyc[4];
        send_frame(4, 9'h0AA, 9, 0, 1'b0, 1, 2'b11, 99);
        step(20);
        chk("t6_data_0aa", 32'(cap_d[4]), 32'h0AA);
        chk("t6_valid_after_rst", 32'(vcyc[4] - base), 1);
        chk("t6_frame_ok", 32'(cap_fe[4]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
